updown_counter_mod: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable and terminal-count pulse. It is the generalised successor to the team's fixed 4-bit free-running up counter. It adds width/modulus parameters, direction control, and a selectable wrap or saturate mode. It is used as a timebase/event counter inside larger blocks and as a cocotb verification target.

---
 rtl/updown_counter_mod.sv | 99 +++++++++
 tb/tb_updown_counter_mod.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulus, parallel load, wrap/saturate and terminal-count pulse.
// Optional sticky overflow flag (ports ovf_clr/ovf_sticky) when COUNTER_OVF_STICKY_EN is defined.
module updown_counter_mod #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  logic [EXT_W-1:0] w_inc_ext;
  logic             w_top;
  logic             w_bottom;
  logic [WIDTH-1:0] w_load_clamped;

  // Increment is evaluated one bit wider so MAX_VAL = 2**WIDTH-1 cannot overflow the compare.
  assign w_inc_ext      = {1'b0, r_count} + EXT_W'(1);
  assign w_top          = (w_inc_ext > MAX_EXT);
  assign w_bottom       = (r_count == '0);
  assign w_load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX_CNT : load_val;

  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (en) begin
      if (up_dn) begin
        if (w_top) begin
          w_tc_nxt    = 1'b1;
          w_count_nxt = SATURATE ? r_count : '0;
        end else begin
          w_count_nxt = w_inc_ext[WIDTH-1:0];
        end
      end else begin
        if (w_bottom) begin
          w_tc_nxt    = 1'b1;
          w_count_nxt = SATURATE ? r_count : MAX_CNT;
        end else begin
          w_count_nxt = r_count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign at_max  = (r_count == MAX_CNT);
  assign at_zero = w_bottom;

`ifdef COUNTER_OVF_STICKY_EN
  logic r_ovf_sticky;

  // A new terminal-count event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_tc_nxt) begin
      r_ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: three instances (mod-10 wrap, mod-10 saturate, default mod-16).
// Sticky overflow sequence runs only when COUNTER_OVF_STICKY_EN is defined.
module tb_updown_counter_mod;

  localparam int unsigned W = 4;

  typedef struct {
    int         sel;
    logic       rst;
    logic       en;
    logic       ud;
    logic       ld;
    logic [W-1:0] lv;
    logic [W-1:0] cnt;
    logic       tc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, en, up_dn, load;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt_a, cnt_b, cnt_c;
  logic         tc_a, tc_b, tc_c;
  logic         max_a, max_b, max_c;
  logic         zero_a, zero_b, zero_c;
`ifdef COUNTER_OVF_STICKY_EN
  logic         ovf_clr;
  logic         ovf_a, ovf_b, ovf_c;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef COUNTER_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_a),
`endif
    .count(cnt_a), .tc(tc_a), .at_max(max_a), .at_zero(zero_a));

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_b (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef COUNTER_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_b),
`endif
    .count(cnt_b), .tc(tc_b), .at_max(max_b), .at_zero(zero_b));

  updown_counter_mod u_c (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef COUNTER_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_c),
`endif
    .count(cnt_c), .tc(tc_c), .at_max(max_c), .at_zero(zero_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [W-1:0] v);
    reset = r; en = e; up_dn = u; load = l; load_val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int sel, input logic r, input logic e, input logic u, input logic l,
                     input logic [W-1:0] v, input logic [W-1:0] c, input logic t);
    vec_t x;
    x.sel = sel; x.rst = r; x.en = e; x.ud = u; x.ld = l; x.lv = v; x.cnt = c; x.tc = t;
    vq.push_back(x);
  endtask

  task automatic check_vec(input int idx, input vec_t x);
    logic [W-1:0] c;
    logic         t, mx, zr;
    logic [W-1:0] maxv;
    case (x.sel)
      0:       begin c = cnt_a; t = tc_a; mx = max_a; zr = zero_a; maxv = 4'd9;  end
      1:       begin c = cnt_b; t = tc_b; mx = max_b; zr = zero_b; maxv = 4'd9;  end
      default: begin c = cnt_c; t = tc_c; mx = max_c; zr = zero_c; maxv = 4'd15; end
    endcase
    check($sformatf("v%0d count", idx), 32'(c), 32'(x.cnt));
    check($sformatf("v%0d tc", idx), 32'(t), 32'(x.tc));
    check($sformatf("v%0d at_max", idx), 32'(mx), 32'(x.cnt == maxv));
    check($sformatf("v%0d at_zero", idx), 32'(zr), 32'(x.cnt == '0));
  endtask

  initial begin
    int ntc;
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
`ifdef COUNTER_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif

    // Wrap instance: reset, count up through the wrap, load then count down through the wrap.
    add(0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++)
      add(0, 0, 1, 1, 0, 0, 4'(i % 10), logic'(i == 10));
    add(0, 0, 0, 1, 1, 3, 3, 0);
    add(0, 0, 1, 0, 0, 0, 2, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 9, 1);
    add(0, 0, 1, 0, 0, 0, 8, 0);
    add(0, 0, 1, 1, 0, 0, 9, 0);
    add(0, 0, 1, 0, 0, 0, 8, 0);
    add(0, 0, 0, 1, 0, 0, 8, 0);
    add(0, 0, 1, 1, 1, 15, 9, 0);
    add(0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 5, 5, 0);
    add(0, 1, 1, 1, 1, 7, 0, 0);
    add(0, 0, 0, 1, 1, 9, 9, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Saturating instance: hold at both boundaries with repeating tc.
    add(1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 8, 8, 0);
    add(1, 0, 1, 1, 0, 0, 9, 0);
    add(1, 0, 1, 1, 0, 0, 9, 1);
    add(1, 0, 1, 1, 0, 0, 9, 1);
    add(1, 0, 1, 1, 0, 0, 9, 1);
    add(1, 0, 1, 0, 0, 0, 8, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, 0);
    add(1, 0, 1, 1, 1, 12, 9, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].en, vq[i].ud, vq[i].ld, vq[i].lv);
      check_vec(i, vq[i]);
    end

    // Default instance: a full lap of 16 up steps yields exactly one tc.
    drive(1, 0, 1, 0, 0);
    check("c reset count", 32'(cnt_c), 32'd0);
    check("c reset at_zero", 32'(zero_c), 32'd1);
    ntc = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 1, 0, 0);
      check($sformatf("c lap%0d count", i), 32'(cnt_c), 32'((i + 1) % 16));
      check($sformatf("c lap%0d tc", i), 32'(tc_c), 32'(i == 15));
      if (tc_c) ntc++;
    end
    check("c lap tc total", 32'(ntc), 32'd1);
    check("c lap at_max", 32'(max_c), 32'd0);

`ifdef COUNTER_OVF_STICKY_EN
    drive(1, 0, 1, 0, 0);
    check("ovf reset", 32'(ovf_a), 32'd0);
    drive(0, 0, 1, 1, 9);
    check("ovf after load", 32'(ovf_a), 32'd0);
    drive(0, 1, 1, 0, 0);
    check("ovf wrap count", 32'(cnt_a), 32'd0);
    check("ovf wrap set", 32'(ovf_a), 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 0, 0);
      check($sformatf("ovf hold%0d", i), 32'(ovf_a), 32'd1);
    end
    drive(0, 0, 1, 1, 9);
    ovf_clr = 1'b1;
    drive(0, 1, 1, 0, 0);
    check("ovf set beats clr", 32'(ovf_a), 32'd1);
    drive(0, 0, 1, 0, 0);
    check("ovf clr alone", 32'(ovf_a), 32'd0);
    ovf_clr = 1'b0;
    drive(0, 0, 1, 0, 0);
    check("ovf stays clear", 32'(ovf_a), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
